// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver and key decoder: BCD duration entry, Enter, and auto-food keys.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames with even data+parity.
module ps2_key_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [15:0] keyDuration,
  output logic        keyboardEnter,
  output logic        keyUpdated,
  output logic [2:0]  keyAutoMode,
  output logic        keyAutoChanged,
  output logic        frameError
);

  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  localparam logic [0:0] DEC_MAKE  = 1'b0;
  localparam logic [0:0] DEC_BREAK = 1'b1;

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  // Returns {valid, digit} for a numeric make code.
  function automatic logic [4:0] digit_lut(input logic [7:0] code);
    case (code)
      8'h45:   digit_lut = {1'b1, 4'd0};
      8'h16:   digit_lut = {1'b1, 4'd1};
      8'h1E:   digit_lut = {1'b1, 4'd2};
      8'h26:   digit_lut = {1'b1, 4'd3};
      8'h25:   digit_lut = {1'b1, 4'd4};
      8'h2E:   digit_lut = {1'b1, 4'd5};
      8'h36:   digit_lut = {1'b1, 4'd6};
      8'h3D:   digit_lut = {1'b1, 4'd7};
      8'h3E:   digit_lut = {1'b1, 4'd8};
      8'h46:   digit_lut = {1'b1, 4'd9};
      default: digit_lut = 5'b0_0000;
    endcase
  endfunction

  // Returns {valid, mode} for an auto-food make code.
  function automatic logic [3:0] auto_lut(input logic [7:0] code);
    case (code)
      8'h4D:   auto_lut = {1'b1, 3'd0};
      8'h44:   auto_lut = {1'b1, 3'd1};
      8'h3A:   auto_lut = {1'b1, 3'd2};
      8'h2A:   auto_lut = {1'b1, 3'd3};
      8'h32:   auto_lut = {1'b1, 3'd4};
      8'h2D:   auto_lut = {1'b1, 3'd5};
      8'h23:   auto_lut = {1'b1, 3'd6};
      8'h1C:   auto_lut = {1'b1, 3'd7};
      default: auto_lut = 4'b0_000;
    endcase
  endfunction

  logic             ps2_clk_meta_q, ps2_clk_sync_q, ps2_clk_prev_q;
  logic             ps2_dat_meta_q, ps2_dat_sync_q;
  logic             ps2_fall_s;
  logic             parity_ok_s;

  logic [1:0]       rx_state_q, rx_state_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic             byte_valid_q, byte_valid_d;
  logic             frame_err_q, frame_err_d;

  logic [0:0]       dec_state_q, dec_state_d;
  logic [15:0]      key_dur_q, key_dur_d;
  logic [2:0]       auto_mode_q, auto_mode_d;
  logic             enter_q, enter_d;
  logic             updated_q, updated_d;
  logic             auto_chg_q, auto_chg_d;
  logic [4:0]       digit_s;
  logic [3:0]       auto_s;

  assign ps2_fall_s = ps2_clk_prev_q & ~ps2_clk_sync_q;

`ifdef PS2_PARITY_CHECK_EN
  logic par_q, par_d;

  // Odd parity over data and parity bit is the only accepted form.
  function automatic logic odd_parity(input logic [7:0] data, input logic par);
    odd_parity = ^{data, par};
  endfunction

  assign parity_ok_s = odd_parity(shift_q, par_q);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`else
  assign parity_ok_s = 1'b1;
`endif

  // Two-flop synchronizers plus a delayed copy of ps2_clk for falling-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ps2_clk_meta_q <= 1'b0;
      ps2_clk_sync_q <= 1'b0;
      ps2_clk_prev_q <= 1'b0;
      ps2_dat_meta_q <= 1'b0;
      ps2_dat_sync_q <= 1'b0;
    end else begin
      ps2_clk_meta_q <= ps2_clk;
      ps2_clk_sync_q <= ps2_clk_meta_q;
      ps2_clk_prev_q <= ps2_clk_sync_q;
      ps2_dat_meta_q <= ps2_dat;
      ps2_dat_sync_q <= ps2_dat_meta_q;
    end
  end

  // Receiver next state: frame bits on each falling edge, timeout while mid-frame.
  always_comb begin
    rx_state_d   = rx_state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    tmo_cnt_d    = tmo_cnt_q;
    byte_d       = byte_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d        = par_q;
`endif
    if (ps2_fall_s) begin
      tmo_cnt_d = '0;
      case (rx_state_q)
        RX_IDLE: begin
          bit_cnt_d = 3'd0;
          if (!ps2_dat_sync_q) begin
            rx_state_d = RX_DATA;
          end else begin
            rx_state_d = RX_IDLE;
          end
        end
        RX_DATA: begin
          shift_d = {ps2_dat_sync_q, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            bit_cnt_d  = 3'd0;
            rx_state_d = RX_PARITY;
          end else begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
          end
        end
        RX_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d      = ps2_dat_sync_q;
`endif
          rx_state_d = RX_STOP;
        end
        RX_STOP: begin
          rx_state_d = RX_IDLE;
          bit_cnt_d  = 3'd0;
          if (ps2_dat_sync_q && parity_ok_s) begin
            byte_d       = shift_q;
            byte_valid_d = 1'b1;
          end else begin
            frame_err_d  = 1'b1;
          end
        end
        default: begin
          rx_state_d = RX_IDLE;
          bit_cnt_d  = 3'd0;
        end
      endcase
    end else if (rx_state_q != RX_IDLE) begin
      if (tmo_cnt_q == TMO_LAST) begin
        rx_state_d  = RX_IDLE;
        bit_cnt_d   = 3'd0;
        tmo_cnt_d   = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_cnt_d   = tmo_cnt_q + {{(TMO_W-1){1'b0}}, 1'b1};
      end
    end else begin
      tmo_cnt_d = '0;
    end
  end

  // Receiver state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_state_q   <= RX_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      tmo_cnt_q    <= '0;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_state_q   <= rx_state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      tmo_cnt_q    <= tmo_cnt_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  assign digit_s = digit_lut(byte_q);
  assign auto_s  = auto_lut(byte_q);

  // Decoder next state: E0 prefix is transparent, F0 swallows the following byte.
  always_comb begin
    dec_state_d = dec_state_q;
    key_dur_d   = key_dur_q;
    auto_mode_d = auto_mode_q;
    enter_d     = 1'b0;
    updated_d   = 1'b0;
    auto_chg_d  = 1'b0;
    if (byte_valid_q) begin
      if (byte_q == 8'hE0) begin
        dec_state_d = dec_state_q;
      end else if (dec_state_q == DEC_BREAK) begin
        dec_state_d = DEC_MAKE;
      end else if (byte_q == 8'hF0) begin
        dec_state_d = DEC_BREAK;
      end else if (digit_s[4]) begin
        key_dur_d = {key_dur_q[11:0], digit_s[3:0]};
        updated_d = 1'b1;
      end else if (byte_q == 8'h66) begin
        key_dur_d = {4'h0, key_dur_q[15:4]};
        updated_d = 1'b1;
      end else if (byte_q == 8'h76) begin
        key_dur_d = 16'h0000;
        updated_d = 1'b1;
      end else if (byte_q == 8'h5A) begin
        enter_d = 1'b1;
      end else if (auto_s[3]) begin
        auto_mode_d = auto_s[2:0];
        auto_chg_d  = 1'b1;
      end else begin
        dec_state_d = DEC_MAKE;
      end
    end else begin
      dec_state_d = dec_state_q;
    end
  end

  // Decoder and output registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dec_state_q <= DEC_MAKE;
      key_dur_q   <= 16'h0000;
      auto_mode_q <= 3'd0;
      enter_q     <= 1'b0;
      updated_q   <= 1'b0;
      auto_chg_q  <= 1'b0;
    end else begin
      dec_state_q <= dec_state_d;
      key_dur_q   <= key_dur_d;
      auto_mode_q <= auto_mode_d;
      enter_q     <= enter_d;
      updated_q   <= updated_d;
      auto_chg_q  <= auto_chg_d;
    end
  end

  assign keyDuration    = key_dur_q;
  assign keyboardEnter  = enter_q;
  assign keyUpdated     = updated_q;
  assign keyAutoMode    = auto_mode_q;
  assign keyAutoChanged = auto_chg_q;
  assign frameError     = frame_err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: vector table of frames plus stop/parity/timeout/reset sequences.
module tb_ps2_key_decoder;

  localparam int TMO  = 200;
  localparam int HALF = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [15:0] keyDuration;
  logic        keyboardEnter, keyUpdated, keyAutoChanged, frameError;
  logic [2:0]  keyAutoMode;

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
    .keyDuration(keyDuration), .keyboardEnter(keyboardEnter), .keyUpdated(keyUpdated),
    .keyAutoMode(keyAutoMode), .keyAutoChanged(keyAutoChanged), .frameError(frameError)
  );

  always #10 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int n_upd = 0, n_ent = 0, n_chg = 0, n_err = 0;
  int excl_viol = 0, wide_viol = 0;
  logic prev_upd = 1'b0, prev_ent = 1'b0, prev_chg = 1'b0, prev_err = 1'b0;

  // Pulse monitor sampled away from the active edge.
  always @(negedge clock) begin
    if (keyUpdated) n_upd++;
    if (keyboardEnter) n_ent++;
    if (keyAutoChanged) n_chg++;
    if (frameError) n_err++;
    if (int'(keyUpdated) + int'(keyboardEnter) + int'(keyAutoChanged) > 1) excl_viol++;
    if ((keyUpdated && prev_upd) || (keyboardEnter && prev_ent) ||
        (keyAutoChanged && prev_chg) || (frameError && prev_err)) wide_viol++;
    prev_upd = keyUpdated;
    prev_ent = keyboardEnter;
    prev_chg = keyAutoChanged;
    prev_err = frameError;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge clock);
    ps2_dat = b;
    repeat (HALF) @(negedge clock);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clock);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit((~^b) ^ bad_par);
    ps2_bit(stop);
    ps2_dat = 1'b1;
    repeat (30) @(negedge clock);
  endtask

  typedef struct packed {
    logic [7:0]  code;
    logic [15:0] dur;
    logic [2:0]  mode;
    logic        upd;
    logic        ent;
    logic        chg;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs [NV];

  int b_upd, b_ent, b_chg, b_err;
  logic [15:0] exp_dur;

  task automatic snap();
    b_upd = n_upd; b_ent = n_ent; b_chg = n_chg; b_err = n_err;
  endtask

  initial begin
    vecs[0]  = '{8'h16, 16'h0001, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{8'h1E, 16'h0012, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{8'h26, 16'h0123, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{8'h5A, 16'h0123, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{8'h76, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{8'h3E, 16'h0008, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{8'hF0, 16'h0008, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{8'h3E, 16'h0008, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{8'h16, 16'h0081, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{8'h1E, 16'h0812, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{8'h26, 16'h8123, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{8'h25, 16'h1234, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{8'h2E, 16'h2345, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[13] = '{8'h66, 16'h0234, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[14] = '{8'h76, 16'h0000, 3'd0, 1'b1, 1'b0, 1'b0};
    vecs[15] = '{8'h2D, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{8'hE0, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{8'h1C, 16'h0000, 3'd7, 1'b0, 1'b0, 1'b1};
    vecs[18] = '{8'h33, 16'h0000, 3'd7, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{8'h45, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b0};
    vecs[20] = '{8'h46, 16'h0009, 3'd7, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{8'h46, 16'h0099, 3'd7, 1'b1, 1'b0, 1'b0};
    vecs[22] = '{8'h3D, 16'h0997, 3'd7, 1'b1, 1'b0, 1'b0};
    vecs[23] = '{8'h4D, 16'h0997, 3'd0, 1'b0, 1'b0, 1'b1};

    // Reset state while reset is held.
    repeat (3) @(negedge clock);
    check("rst_dur", int'(keyDuration), 16'h0000);
    check("rst_mode", int'(keyAutoMode), 3'd0);
    check("rst_pulses", int'({keyboardEnter, keyUpdated, keyAutoChanged, frameError}), 4'b0000);
    reset = 1'b0;
    repeat (5) @(negedge clock);

    for (int i = 0; i < NV; i++) begin
      snap();
      send_frame(vecs[i].code, 1'b0, 1'b1);
      check($sformatf("v%0d_dur", i), int'(keyDuration), int'(vecs[i].dur));
      check($sformatf("v%0d_mode", i), int'(keyAutoMode), int'(vecs[i].mode));
      check($sformatf("v%0d_upd", i), n_upd - b_upd, int'(vecs[i].upd));
      check($sformatf("v%0d_ent", i), n_ent - b_ent, int'(vecs[i].ent));
      check($sformatf("v%0d_chg", i), n_chg - b_chg, int'(vecs[i].chg));
      check($sformatf("v%0d_err", i), n_err - b_err, 0);
    end
    exp_dur = 16'h0997;

    // Bad stop bit: byte dropped.
    snap();
    send_frame(8'h16, 1'b0, 1'b0);
    check("stop_err", n_err - b_err, 1);
    check("stop_upd", n_upd - b_upd, 0);
    check("stop_dur", int'(keyDuration), int'(exp_dur));

    // Wrong parity on 0x16.
    snap();
    send_frame(8'h16, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("par_err", n_err - b_err, 1);
    check("par_upd", n_upd - b_upd, 0);
`else
    exp_dur = {exp_dur[11:0], 4'h1};
    check("par_err", n_err - b_err, 0);
    check("par_upd", n_upd - b_upd, 1);
`endif
    check("par_dur", int'(keyDuration), int'(exp_dur));

    // Partial frame then idle: timeout discards it.
    snap();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    ps2_dat = 1'b1;
    repeat (TMO + 50) @(negedge clock);
    check("tmo_err", n_err - b_err, 1);
    check("tmo_dur", int'(keyDuration), int'(exp_dur));
    snap();
    send_frame(8'h45, 1'b0, 1'b1);
    exp_dur = {exp_dur[11:0], 4'h0};
    check("tmo_next_dur", int'(keyDuration), int'(exp_dur));
    check("tmo_next_upd", n_upd - b_upd, 1);
    check("tmo_next_err", n_err - b_err, 0);

    // Asynchronous reset in the middle of a frame.
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b0);
    #3 reset = 1'b1;
    #1;
    check("arst_dur", int'(keyDuration), 16'h0000);
    check("arst_mode", int'(keyAutoMode), 3'd0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    ps2_dat = 1'b1;
    repeat (5) @(negedge clock);
    snap();
    send_frame(8'h1E, 1'b0, 1'b1);
    check("arst_next_dur", int'(keyDuration), 16'h0002);
    check("arst_next_upd", n_upd - b_upd, 1);
    check("arst_next_err", n_err - b_err, 0);

    check("pulse_exclusive", excl_viol, 0);
    check("pulse_width", wide_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
